// File: rtl/rc4_stream_xor.sv
// Consumer side of the RC4 keystream interface: buffers keystream bytes, optionally
// drops a prefix, and XORs each message byte with the next keystream byte.
module rc4_stream_xor #(
    parameter int KS_DEPTH = 4,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [LEN_W-1:0] drop_len,
    input  logic [7:0]       ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(KS_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DROP  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_next;

    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] fetch;
    logic [LEN_W-1:0] drop_cnt;

    logic [7:0]  mem [KS_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;

    logic ks_xfer;
    logic din_xfer;
    logic dout_xfer;
    logic push;

    // One extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign ks_xfer   = ks_valid && ks_ready;
    assign din_xfer  = din_valid && din_ready;
    assign dout_xfer = dout_valid && dout_ready;
    assign push      = ks_xfer && (state == RUN);
    assign busy      = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ks_ready   = 1'b0;
        din_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (msg_len != '0))
                    state_next = (drop_len != '0) ? DROP : RUN;
            end
            DROP: begin
                ks_ready = 1'b1;
                if (ks_valid && (drop_cnt == LEN_W'(1)))
                    state_next = RUN;
            end
            RUN: begin
                ks_ready  = !fifo_full && (fetch != '0);
                din_ready = !fifo_empty && (!dout_valid || dout_ready);
                if (din_valid && din_ready && (remain == LEN_W'(1)))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (dout_xfer && dout_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain     <= '0;
            fetch      <= '0;
            drop_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remain   <= msg_len;
                        fetch    <= msg_len;
                        drop_cnt <= drop_len;
                        done     <= (msg_len == '0);
                    end
                end
                DROP: begin
                    if (ks_xfer)
                        drop_cnt <= drop_cnt - LEN_W'(1);
                end
                RUN: begin
                    if (push)
                        fetch <= fetch - LEN_W'(1);
                    if (din_xfer)
                        remain <= remain - LEN_W'(1);
                end
                DRAIN: begin
                    if (dout_xfer && dout_last)
                        done <= 1'b1;
                end
                default: ;
            endcase

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            // A new byte may replace the held one in the same cycle it is taken.
            if (din_xfer) begin
                rd_ptr     <= rd_ptr + 1'b1;
                dout       <= din ^ mem[rd_ptr[AW-1:0]];
                dout_valid <= 1'b1;
                dout_last  <= (remain == LEN_W'(1));
            end else if (dout_xfer) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is not reset; the pointers alone define which
    // entries hold valid keystream, so clearing the bytes buys nothing.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= ks_data;
    end

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Self-checking bench for rc4_stream_xor: directed scenarios plus randomized
// messages, checked against a queue model (dout[i] = din[i] ^ ks[drop + i]).
module tb_rc4_stream_xor;

    localparam int KS_DEPTH = 4;
    localparam int LEN_W    = 16;
    localparam int BUDGET   = 3000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic [LEN_W-1:0] drop_len;
    logic [7:0]       ks_data;
    logic             ks_valid;
    logic             ks_ready;
    logic [7:0]       din;
    logic             din_valid;
    logic             din_ready;
    logic [7:0]       dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             busy;
    logic             done;

    rc4_stream_xor #(
        .KS_DEPTH (KS_DEPTH),
        .LEN_W    (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg_len    (msg_len),
        .drop_len   (drop_len),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] ks_q[$];
    logic [7:0] din_q[$];
    logic [7:0] got_q[$];
    int         ks_count;
    bit         sink_done;

    logic [7:0] kv_ks[9]  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] kv_out[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    string      kv_pt     = "Plaintext";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ks_ready"},   ks_ready,   0);
        check({tag, "_din_ready"},  din_ready,  0);
        check({tag, "_dout"},       dout,       0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_dout_last"},  dout_last,  0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
    endtask

    task automatic load_known_vector();
        ks_q.delete();
        din_q.delete();
        foreach (kv_ks[i]) ks_q.push_back(kv_ks[i]);
        for (int i = 0; i < 6; i++) ks_q.push_back(8'($urandom));
        for (int i = 0; i < kv_pt.len(); i++) din_q.push_back(kv_pt[i]);
    endtask

    task automatic fill_random(input int len, input int drop);
        ks_q.delete();
        din_q.delete();
        for (int i = 0; i < drop + len + KS_DEPTH + 2; i++) ks_q.push_back(8'($urandom));
        for (int i = 0; i < len; i++) din_q.push_back(8'($urandom));
    endtask

    task automatic check_known_result(input string tag);
        check({tag, "_count"}, got_q.size(), 9);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], kv_out[i]);
    endtask

    // One message: ks source, din source and dout sink run concurrently, each
    // bounded by BUDGET cycles; an optional stall and an optional stray start.
    task automatic run_msg(input int len, input int drop, input int ks_gap,
                           input int din_gap, input int rdy_pct,
                           input int stall_at, input int restart_at);
        got_q.delete();
        ks_count  = 0;
        sink_done = 0;
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        msg_len  = LEN_W'(len);
        drop_len = LEN_W'(drop);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        msg_len  = LEN_W'($urandom);
        drop_len = LEN_W'($urandom);
        #1;
        check("busy_after_start", busy, 1);
        fork
            begin : ks_src
                int idx = 0;
                int cyc = 0;
                bit pend = 0;
                while (cyc < BUDGET) begin
                    @(negedge clk);
                    cyc++;
                    if (pend) begin
                        idx++;
                        pend = 0;
                        ks_valid = 1'b0;
                    end
                    if (sink_done) break;
                    if (!ks_valid && int'($urandom_range(99)) >= ks_gap) begin
                        ks_valid = 1'b1;
                        ks_data  = (idx < ks_q.size()) ? ks_q[idx] : 8'hA5;
                    end
                    #1;
                    if (ks_valid && ks_ready) begin
                        pend = 1;
                        ks_count++;
                    end
                end
                ks_valid = 1'b0;
            end
            begin : din_src
                int idx = 0;
                int cyc = 0;
                bit pend = 0;
                while (idx < len && cyc < BUDGET && !sink_done) begin
                    @(negedge clk);
                    cyc++;
                    if (pend) begin
                        idx++;
                        pend = 0;
                        din_valid = 1'b0;
                    end
                    if (idx < len && !din_valid && int'($urandom_range(99)) >= din_gap) begin
                        din_valid = 1'b1;
                        din       = din_q[idx];
                    end
                    #1;
                    if (din_valid && din_ready) pend = 1;
                end
                din_valid = 1'b0;
            end
            begin : dout_sink
                int n = 0;
                int cyc = 0;
                int st = 0;
                logic [7:0] ref_d;
                logic       ref_v;
                logic [7:0] exp_d;
                while (n < len && cyc < BUDGET) begin
                    @(negedge clk);
                    cyc++;
                    if (stall_at > 0 && n == stall_at && st < 6) begin
                        dout_ready = 1'b0;
                        st++;
                        #1;
                        if (st == 3) begin
                            ref_d = dout;
                            ref_v = dout_valid;
                        end else if (st > 3) begin
                            check("stall_dout_stable",  dout,       ref_d);
                            check("stall_valid_stable", dout_valid, ref_v);
                        end
                        if (st == 6) begin
                            check("stall_dout_valid", dout_valid, 1);
                            check("stall_din_ready",  din_ready,  0);
                            check("stall_fifo_full_ks_ready", ks_ready, 0);
                        end
                    end else begin
                        dout_ready = (int'($urandom_range(99)) < rdy_pct);
                        #1;
                        if (dout_valid && dout_ready) begin
                            exp_d = din_q[n] ^ ks_q[drop + n];
                            check($sformatf("dout_byte%0d", n), dout, exp_d);
                            check($sformatf("dout_last_byte%0d", n), dout_last, (n == len - 1));
                            got_q.push_back(dout);
                            n++;
                        end
                    end
                end
                check("dout_count", n, len);
                @(negedge clk);
                #1;
                check("done_pulse", done, 1);
                check("idle_after_msg", busy, 0);
                @(negedge clk);
                #1;
                check("done_one_cycle", done, 0);
                sink_done = 1;
            end
            begin : stray_start
                if (restart_at > 0) begin
                    repeat (restart_at) @(negedge clk);
                    msg_len  = LEN_W'(3);
                    drop_len = LEN_W'(1);
                    start    = 1'b1;
                    @(negedge clk);
                    start    = 1'b0;
                end
            end
        join
        dout_ready = 1'b0;
        check("ks_transfers", ks_count, drop + len);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        msg_len    = '0;
        drop_len   = '0;
        ks_data    = '0;
        ks_valid   = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Known RC4 vector, key "Key", no drop.
        load_known_vector();
        run_msg(9, 0, 0, 0, 100, 0, 0);
        check_known_result("known_vector");

        // Drop prefix of three bytes.
        ks_q  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        din_q = '{8'h00, 8'h00};
        run_msg(2, 3, 0, 0, 100, 0, 0);
        check("drop_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("drop_byte0", got_q[0], 8'h44);
            check("drop_byte1", got_q[1], 8'h55);
        end

        // Backpressure: downstream stalls six cycles mid-message.
        fill_random(16, 0);
        run_msg(16, 0, 0, 0, 100, 3, 0);

        // Zero-length message.
        @(negedge clk);
        msg_len    = '0;
        drop_len   = LEN_W'(5);
        start      = 1'b1;
        ks_valid   = 1'b1;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        #1;
        check("zero_len_ks_ready",  ks_ready,  0);
        check("zero_len_din_ready", din_ready, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_len_done",       done,       1);
        check("zero_len_busy",       busy,       0);
        check("zero_len_ks_ready2",  ks_ready,   0);
        check("zero_len_dout_valid", dout_valid, 0);
        @(negedge clk);
        #1;
        check("zero_len_done_clear", done, 0);
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;

        // Asynchronous reset in the middle of a message.
        @(negedge clk);
        msg_len    = LEN_W'(9);
        drop_len   = '0;
        start      = 1'b1;
        ks_valid   = 1'b1;
        ks_data    = 8'hEB;
        din_valid  = 1'b1;
        din        = 8'h50;
        dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_known_vector();
        run_msg(9, 0, 0, 0, 100, 0, 0);
        check_known_result("after_reset");

        // Stray start while running must be ignored.
        fill_random(12, 2);
        run_msg(12, 2, 20, 20, 70, 0, 4);

        // Randomized messages with irregular handshakes.
        for (int t = 0; t < 8; t++) begin
            int len;
            int drop;
            len  = int'($urandom_range(20, 1));
            drop = int'($urandom_range(5, 0));
            fill_random(len, drop);
            run_msg(len, drop, int'($urandom_range(60)), int'($urandom_range(60)),
                    int'($urandom_range(100, 30)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
